// File: rtl/simple_bus_pkg.sv
// simple_bus_pkg: shared widths, monitor state and error-code enums for the simple bus monitor.
package simple_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_LO = 2'd1,
    DATA    = 2'd2
  } mon_state_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_START_IN_TXN = 2'd1,
    ERR_TIMEOUT      = 2'd2,
    ERR_SPURIOUS_DV  = 2'd3
  } err_code_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; synchronous clear, async active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_inc && r_count != '1) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/simple_bus_monitor.sv
// simple_bus_monitor: passive snooper that rebuilds transaction records and flags protocol errors.
// Define SBMON_STATS_EN to add saturating read/write/error counters.
module simple_bus_monitor
  import simple_bus_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int WAIT_W  = 8
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              start,
  input  logic              read,
  input  logic              dataValid,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic              txnValid,
  output logic              txnRead,
  output logic [ADDR_W-1:0] txnAddr,
  output logic [DATA_W-1:0] txnData,
  output logic [WAIT_W-1:0] txnWait,
  output logic              protoErr,
  output logic [1:0]        errCode,
  output logic              busy
`ifdef SBMON_STATS_EN
  ,
  output logic [15:0]       rdCount,
  output logic [15:0]       wrCount,
  output logic [15:0]       errCount
`endif
);

  logic              w_start, w_read, w_dv;
  mon_state_e        r_state, w_state_nx;
  logic [DATA_W-1:0] r_addr_hi, r_addr_lo, w_addr_hi_nx, w_addr_lo_nx;
  logic              r_rd_flag, w_rd_nx;
  logic [WAIT_W-1:0] r_cnt, w_cnt_nx;
  logic              w_txn, w_err;
  err_code_e         w_err_code;

  logic              r_txn_valid, r_txn_read, r_proto_err, r_busy;
  logic [ADDR_W-1:0] r_txn_addr;
  logic [DATA_W-1:0] r_txn_data;
  logic [WAIT_W-1:0] r_txn_wait;
  err_code_e         r_err_code;

  // The bus floats; only a solid 1 counts as asserted.
  assign w_start = (start === 1'b1);
  assign w_read  = (read === 1'b1);
  assign w_dv    = (dataValid === 1'b1);

  always_comb begin
    w_state_nx   = r_state;
    w_addr_hi_nx = r_addr_hi;
    w_addr_lo_nx = r_addr_lo;
    w_rd_nx      = r_rd_flag;
    w_cnt_nx     = r_cnt;
    w_txn        = 1'b0;
    w_err        = 1'b0;
    w_err_code   = ERR_NONE;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_addr_hi_nx = address;
          w_state_nx   = ADDR_LO;
        end else if (w_dv) begin
          w_err      = 1'b1;
          w_err_code = ERR_SPURIOUS_DV;
        end
      end
      ADDR_LO: begin
        if (w_start) begin
          w_err        = 1'b1;
          w_err_code   = ERR_START_IN_TXN;
          w_addr_hi_nx = address;
        end else begin
          w_addr_lo_nx = address;
          w_rd_nx      = w_read;
          w_cnt_nx     = '0;
          w_state_nx   = DATA;
        end
      end
      DATA: begin
        // A completing dataValid still reports its record even if start collides with it.
        w_txn = w_dv;
        if (w_start) begin
          w_err        = 1'b1;
          w_err_code   = ERR_START_IN_TXN;
          w_addr_hi_nx = address;
          w_state_nx   = ADDR_LO;
        end else if (w_dv) begin
          w_state_nx = IDLE;
        end else if (r_cnt == WAIT_W'(TIMEOUT)) begin
          w_err      = 1'b1;
          w_err_code = ERR_TIMEOUT;
          w_state_nx = IDLE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= IDLE;
      r_addr_hi   <= '0;
      r_addr_lo   <= '0;
      r_rd_flag   <= 1'b0;
      r_cnt       <= '0;
      r_txn_valid <= 1'b0;
      r_txn_read  <= 1'b0;
      r_txn_addr  <= '0;
      r_txn_data  <= '0;
      r_txn_wait  <= '0;
      r_proto_err <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_addr_hi   <= w_addr_hi_nx;
      r_addr_lo   <= w_addr_lo_nx;
      r_rd_flag   <= w_rd_nx;
      r_cnt       <= w_cnt_nx;
      r_txn_valid <= w_txn;
      r_proto_err <= w_err;
      r_busy      <= (w_state_nx != IDLE);
      if (w_txn) begin
        r_txn_read <= r_rd_flag;
        r_txn_addr <= {r_addr_hi, r_addr_lo};
        r_txn_data <= data;
        r_txn_wait <= r_cnt;
      end
      if (w_err) r_err_code <= w_err_code;
    end
  end

  assign txnValid = r_txn_valid;
  assign txnRead  = r_txn_read;
  assign txnAddr  = r_txn_addr;
  assign txnData  = r_txn_data;
  assign txnWait  = r_txn_wait;
  assign protoErr = r_proto_err;
  assign errCode  = r_err_code;
  assign busy     = r_busy;

`ifdef SBMON_STATS_EN
  // Counters step on the same edge that raises the matching pulse.
  sat_counter #(.W(16)) u_rd_cnt (
    .i_clk(clock), .i_rst_n(resetN), .i_inc(w_txn & r_rd_flag), .i_clear(1'b0), .o_count(rdCount)
  );
  sat_counter #(.W(16)) u_wr_cnt (
    .i_clk(clock), .i_rst_n(resetN), .i_inc(w_txn & ~r_rd_flag), .i_clear(1'b0), .o_count(wrCount)
  );
  sat_counter #(.W(16)) u_err_cnt (
    .i_clk(clock), .i_rst_n(resetN), .i_inc(w_err), .i_clear(1'b0), .o_count(errCount)
  );
`endif

endmodule

// File: tb/tb_simple_bus_monitor.sv
// tb_simple_bus_monitor: random transaction-level stimulus against expected records and error codes.
module tb_simple_bus_monitor;

  localparam int TO = 4;
  localparam int WW = 8;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          start = 1'b0, read = 1'b0, dataValid = 1'b0;
  logic [7:0]    address = 8'h00, data = 8'h00;
  logic          txnValid, txnRead, protoErr, busy;
  logic [15:0]   txnAddr;
  logic [7:0]    txnData;
  logic [WW-1:0] txnWait;
  logic [1:0]    errCode;
`ifdef SBMON_STATS_EN
  logic [15:0]   rdCount, wrCount, errCount;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  bit          exp_rd   = 1'b0;
  logic [15:0] exp_addr = 16'h0;
  logic [7:0]  exp_data = 8'h0;
  int          exp_wait = 0;
  int          exp_err  = 0;

  simple_bus_monitor #(.TIMEOUT(TO), .WAIT_W(WW)) dut (
    .clock(clock), .resetN(resetN), .start(start), .read(read), .dataValid(dataValid),
    .address(address), .data(data), .txnValid(txnValid), .txnRead(txnRead),
    .txnAddr(txnAddr), .txnData(txnData), .txnWait(txnWait), .protoErr(protoErr),
    .errCode(errCode), .busy(busy)
`ifdef SBMON_STATS_EN
    , .rdCount(rdCount), .wrCount(wrCount), .errCount(errCount)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_fields();
    check("txnRead", 32'(txnRead), 32'(exp_rd));
    check("txnAddr", 32'(txnAddr), 32'(exp_addr));
    check("txnData", 32'(txnData), 32'(exp_data));
    check("txnWait", 32'(txnWait), 32'(exp_wait));
    check("errCode", 32'(errCode), 32'(exp_err));
  endtask

  task automatic tick_chk(input bit v, input bit e, input bit b);
    @(posedge clock);
    #1;
    check("txnValid", 32'(txnValid), 32'(v));
    check("protoErr", 32'(protoErr), 32'(e));
    check("busy", 32'(busy), 32'(b));
    check_fields();
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      start     = $urandom_range(1) ? 1'bz : 1'b0;
      dataValid = $urandom_range(1) ? 1'bz : 1'bx;
      read      = 1'($urandom);
      address   = 8'($urandom);
      tick_chk(0, 0, 0);
    end
    dataValid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic addr_phase(input bit rd, input logic [15:0] a);
    start = 1'b1; dataValid = 1'b0; address = a[15:8]; read = 1'($urandom);
    tick_chk(0, 0, 1);
    start = 1'b0; read = rd; address = a[7:0];
    tick_chk(0, 0, 1);
  endtask

  task automatic data_wait(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0; read = 1'($urandom); address = 8'($urandom); data = 8'($urandom);
      dataValid = $urandom_range(1) ? 1'bz : 1'b0;
      tick_chk(0, 0, 1);
    end
  endtask

  task automatic data_done(input bit rd, input logic [15:0] a, input logic [7:0] d, input int w);
    start = 1'b0; dataValid = 1'b1; data = d;
    exp_rd = rd; exp_addr = a; exp_data = d; exp_wait = w;
    tick_chk(1, 0, 0);
    dataValid = 1'b0;
  endtask

  task automatic do_txn(input bit rd, input logic [15:0] a, input logic [7:0] d, input int w);
    addr_phase(rd, a);
    data_wait(w);
    data_done(rd, a, d, w);
  endtask

  task automatic do_timeout(input bit rd, input logic [15:0] a);
    addr_phase(rd, a);
    data_wait(TO);
    dataValid = 1'b0; exp_err = 2;
    tick_chk(0, 1, 0);
  endtask

  task automatic do_spurious();
    start = 1'b0; dataValid = 1'b1; exp_err = 3;
    tick_chk(0, 1, 0);
    dataValid = 1'b0;
  endtask

  // Start collides in DATA after k waits, optionally together with dataValid.
  task automatic do_restart_data(input bit with_dv, input int k, input bit rd2,
                                 input logic [15:0] a2, input logic [7:0] d2, input int w2);
    bit          rd1 = 1'($urandom);
    logic [15:0] a1  = 16'($urandom);
    logic [7:0]  d1  = 8'($urandom);
    addr_phase(rd1, a1);
    data_wait(k);
    start = 1'b1; address = a2[15:8]; dataValid = with_dv; data = d1;
    if (with_dv) begin
      exp_rd = rd1; exp_addr = a1; exp_data = d1; exp_wait = k;
    end
    exp_err = 1;
    tick_chk(with_dv, 1, 1);
    start = 1'b0; dataValid = 1'b0; read = rd2; address = a2[7:0];
    tick_chk(0, 0, 1);
    data_wait(w2);
    data_done(rd2, a2, d2, w2);
  endtask

  task automatic do_restart_addr(input bit rd, input logic [15:0] a, input logic [7:0] d, input int w);
    start = 1'b1; address = 8'($urandom);
    tick_chk(0, 0, 1);
    address = a[15:8]; exp_err = 1;
    tick_chk(0, 1, 1);
    start = 1'b0; read = rd; address = a[7:0];
    tick_chk(0, 0, 1);
    data_wait(w);
    data_done(rd, a, d, w);
  endtask

  task automatic reset_mid_data();
    addr_phase(1'b1, 16'($urandom));
    data_wait(1);
    #2 resetN = 1'b0;
    #1;
    exp_rd = 0; exp_addr = 0; exp_data = 0; exp_wait = 0; exp_err = 0;
    check("rst_valid", 32'(txnValid), 32'h0);
    check("rst_perr", 32'(protoErr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check_fields();
    dataValid = 1'b1; data = 8'hEE;
    tick_chk(0, 0, 0);
    dataValid = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    idle_gap(1);
  endtask

  initial begin
    #12;
    check("init_valid", 32'(txnValid), 32'h0);
    check("init_perr", 32'(protoErr), 32'h0);
    check("init_busy", 32'(busy), 32'h0);
    check_fields();
    @(negedge clock);
    resetN = 1'b1;
    idle_gap(2);

    do_txn(1'b1, 16'hA35C, 8'h5C, 2);
    idle_gap(1);
    do_txn(1'b0, 16'h0102, 8'h7E, 0);
    do_txn(1'b1, 16'h1234, 8'hC3, 1);
    do_txn(1'b0, 16'h4321, 8'h3C, 0);
    idle_gap(1);
    do_timeout(1'b1, 16'hBEEF);
    idle_gap(1);
    do_spurious();
    idle_gap(1);
    do_restart_data(1'b0, 1, 1'b1, 16'h5AA5, 8'h99, 1);
    do_restart_data(1'b1, 2, 1'b0, 16'hC001, 8'h11, TO);
    do_restart_addr(1'b1, 16'h7F80, 8'h42, 0);
    idle_gap(1);
    reset_mid_data();
`ifdef SBMON_STATS_EN
    check("rdCount_rst", 32'(rdCount), 32'h0);
    check("errCount_rst", 32'(errCount), 32'h0);
    do_txn(1'b1, 16'h0010, 8'h01, 0);
    do_txn(1'b1, 16'h0020, 8'h02, 3);
    idle_gap(1);
    check("rdCount_2", 32'(rdCount), 32'h2);
    check("wrCount_0", 32'(wrCount), 32'h0);
`endif

    for (int i = 0; i < 200; i++) begin
      bit          rd = 1'($urandom);
      logic [15:0] a  = 16'($urandom);
      logic [7:0]  d  = 8'($urandom);
      int          w  = $urandom_range(TO);
      case ($urandom_range(6))
        0, 1: do_txn(rd, a, d, w);
        2: do_timeout(rd, a);
        3: do_spurious();
        4: do_restart_data(1'b0, $urandom_range(TO), rd, a, d, w);
        5: do_restart_data(1'b1, $urandom_range(TO), rd, a, d, w);
        default: do_restart_addr(rd, a, d, w);
      endcase
      idle_gap($urandom_range(2));
      if (i == 100) reset_mid_data();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
